gpu_instruction_dispatch: RTL and testbench

//  Sequencer between the GPU instruction FIFO and the draw engines (line, rect fill, circle) plus the frame-buffer swap logic.

---
 rtl/gpu_instruction_dispatch_if.sv | 32 +++
 rtl/gpu_instruction_dispatch.sv | 150 +++++++++++++++
 tb/tb_gpu_instruction_dispatch.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_instruction_dispatch_if.sv
// Dispatch bus: FIFO head/pop, engine start/done/abort, buffer swap handshake and status.
interface gpu_instruction_dispatch_if #(
  parameter int INSTR_W = 79
);
  logic               fifo_empty_i;
  logic [INSTR_W-1:0] instr_i;
  logic               pop_o;
  logic [INSTR_W-1:0] instr_o;
  logic [2:0]         start_o;
  logic [2:0]         done_i;
  logic               abort_o;
  logic               swap_req_o;
  logic               swap_ack_i;
  logic               halt_i;
  logic               clear_err_i;
  logic               busy_o;
  logic               illegal_op_o;
  logic               timeout_err_o;
  logic [15:0]        instr_count_o;

  modport master (
    input  fifo_empty_i, instr_i, done_i, swap_ack_i, halt_i, clear_err_i,
    output pop_o, instr_o, start_o, abort_o, swap_req_o, busy_o,
           illegal_op_o, timeout_err_o, instr_count_o
  );

  modport slave (
    output fifo_empty_i, instr_i, done_i, swap_ack_i, halt_i, clear_err_i,
    input  pop_o, instr_o, start_o, abort_o, swap_req_o, busy_o,
           illegal_op_o, timeout_err_o, instr_count_o
  );
endinterface

// File: rtl/gpu_instruction_dispatch.sv
// Fetches one instruction at a time, starts exactly one draw engine (or a buffer swap)
// and waits for it to finish or time out before fetching the next.
module gpu_instruction_dispatch #(
  parameter int INSTR_W        = 79,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic                        clk,
  input logic                        n_rst,
  gpu_instruction_dispatch_if.master bus
);
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_WAIT, S_SWAP
  } state_t;

  state_t             r_state;
  logic [INSTR_W-1:0] r_instr;
  logic [2:0]         r_sel;
  logic [2:0]         r_start;
  logic               r_pop;
  logic               r_abort;
  logic               r_swap_req;
  logic               r_busy;
  logic               r_illegal;
  logic               r_timeout;
  logic [15:0]        r_count;
  logic [CNT_W-1:0]   r_cnt;

  logic [3:0]         w_opcode;
  logic [2:0]         w_sel;
  logic               w_done;

  assign w_opcode = r_instr[3:0];
  assign w_done   = |(bus.done_i & r_sel);

  always_comb begin
    w_sel = 3'b000;
    case (w_opcode)
      4'd1:    w_sel = 3'b001;
      4'd2:    w_sel = 3'b010;
      4'd3:    w_sel = 3'b100;
      default: w_sel = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_instr    <= '0;
      r_sel      <= 3'b000;
      r_start    <= 3'b000;
      r_pop      <= 1'b0;
      r_abort    <= 1'b0;
      r_swap_req <= 1'b0;
      r_busy     <= 1'b0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
      r_count    <= '0;
      r_cnt      <= '0;
    end else begin
      r_pop   <= 1'b0;
      r_start <= 3'b000;
      r_abort <= 1'b0;
      // Clear first so a set later in this edge overrides it.
      if (bus.clear_err_i) begin
        r_illegal <= 1'b0;
        r_timeout <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!bus.fifo_empty_i && !bus.halt_i) begin
            r_state <= S_FETCH;
            r_pop   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_instr <= bus.instr_i;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (w_opcode)
            4'd0: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_count <= r_count + 16'd1;
            end
            4'd1, 4'd2, 4'd3: begin
              r_state <= S_START;
              r_sel   <= w_sel;
              r_start <= w_sel;
            end
            4'd4: begin
              r_state    <= S_SWAP;
              r_swap_req <= 1'b1;
            end
            default: begin
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last allowed cycle beats the timeout.
          if (w_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_count <= r_count + 16'd1;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_abort   <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SWAP: begin
          if (bus.swap_ack_i) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_swap_req <= 1'b0;
            r_count    <= r_count + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pop_o         = r_pop;
  assign bus.instr_o       = r_instr;
  assign bus.start_o       = r_start;
  assign bus.abort_o       = r_abort;
  assign bus.swap_req_o    = r_swap_req;
  assign bus.busy_o        = r_busy;
  assign bus.illegal_op_o  = r_illegal;
  assign bus.timeout_err_o = r_timeout;
  assign bus.instr_count_o = r_count;
endmodule

// File: tb/tb_gpu_instruction_dispatch.sv
// Bench for gpu_instruction_dispatch: FIFO/engine/swap environment, timeline reference model, per-cycle compare.
module tb_gpu_instruction_dispatch;
  localparam int W  = 79;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  gpu_instruction_dispatch_if #(.INSTR_W(W)) bus();
  gpu_instruction_dispatch #(.INSTR_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // environment
  logic [W-1:0] fifo[$];
  int           dly_q[$];
  int           pop_log[$];
  int           st_cyc[$];
  logic [2:0]   st_val[$];
  int           ab_log[$];
  int           swap_hi = 0;
  int           push_rate = 0;
  int           halt_mode = 0;
  bit           clr_rand = 1'b0;
  bit           clr_once = 1'b0;
  bit           rst_drive = 1'b0;

  // reference model: one in-flight instruction described by its fetch cycle and last busy cycle
  bit           m_have = 1'b0;
  int           m_fc = -10;
  int           m_end = -10;
  int           m_dly = 0;
  bit           m_tmo = 1'b0;
  logic [3:0]   m_op = 4'd0;
  logic [W-1:0] m_word = '0;

  logic         exp_pop = 1'b0, exp_busy = 1'b0, exp_abort = 1'b0, exp_swap = 1'b0;
  logic         exp_ill = 1'b0, exp_tmo = 1'b0;
  logic [2:0]   exp_start = 3'b000;
  logic [15:0]  exp_count = 16'd0;
  logic [W-1:0] exp_instr = '0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] eng(input logic [3:0] op);
    eng = (op == 4'd1) ? 3'b001 : (op == 4'd2) ? 3'b010 : (op == 4'd3) ? 3'b100 : 3'b000;
  endfunction

  function automatic logic [W-1:0] mkw(input logic [3:0] op);
    logic [95:0] r;
    r   = {$urandom, $urandom, $urandom};
    mkw = {r[W-1:4], op};
  endfunction

  function automatic logic [3:0] rand_op();
    int k;
    k = $urandom_range(0, 7);
    rand_op = (k < 5) ? 4'(k) : 4'($urandom_range(5, 15));
  endfunction

  function automatic int next_delay(input int mx);
    if (dly_q.size() > 0) next_delay = dly_q.pop_front();
    else next_delay = $urandom_range(0, mx);
  endfunction

  task automatic model_reset();
    m_have = 1'b0; m_fc = -10; m_end = -10; m_tmo = 1'b0; m_op = 4'd0;
    exp_pop = 1'b0; exp_busy = 1'b0; exp_abort = 1'b0; exp_swap = 1'b0;
    exp_ill = 1'b0; exp_tmo = 1'b0; exp_start = 3'b000; exp_count = 16'd0; exp_instr = '0;
  endtask

  // Expected outputs for cycle n, read off the in-flight instruction's timeline.
  task automatic predict(input int n, input logic clr);
    logic [2:0] e;
    e         = eng(m_op);
    exp_pop   = m_have && (n == m_fc);
    exp_busy  = m_have && (n >= m_fc) && (n <= m_end);
    exp_start = (m_have && n == m_fc + 2) ? e : 3'b000;
    exp_swap  = m_have && (m_op == 4'd4) && (n >= m_fc + 2) && (n <= m_end);
    exp_abort = m_have && (e != 3'b000) && m_tmo && (n == m_end + 1);
    if (m_have && n == m_fc + 1) exp_instr = m_word;
    if (clr) begin exp_ill = 1'b0; exp_tmo = 1'b0; end
    if (m_have && n == m_end + 1) begin
      if (m_op > 4'd4) exp_ill = 1'b1;
      else if (m_tmo) exp_tmo = 1'b1;
      else exp_count = exp_count + 16'd1;
    end
  endtask

  // One cycle: drive inputs for cycle j, advance the model, predict cycle j+1.
  task automatic step();
    int         j;
    logic [2:0] sel;
    logic [2:0] dn;
    @(negedge clk);
    #1;
    j     = cyc;
    n_rst = rst_drive;
    if (push_rate > 0 && fifo.size() < 4 && $urandom_range(0, 99) < push_rate)
      fifo.push_back(mkw(rand_op()));
    bus.halt_i      = (halt_mode == 1) || (halt_mode == 2 && $urandom_range(0, 3) == 0);
    bus.clear_err_i = clr_once || (clr_rand && $urandom_range(0, 9) == 0);
    clr_once        = 1'b0;
    sel = m_have ? eng(m_op) : 3'b000;
    dn  = 3'($urandom_range(0, 7)) & ~sel;
    if (sel != 3'b000 && !m_tmo && j == m_fc + 3 + m_dly) dn = dn | sel;
    bus.done_i = dn;
    if (m_have && m_op == 4'd4 && j >= m_fc && j <= m_end) bus.swap_ack_i = (j == m_end);
    else bus.swap_ack_i = 1'($urandom_range(0, 1));
    bus.fifo_empty_i = (fifo.size() == 0);
    bus.instr_i      = (fifo.size() > 0) ? fifo[0] : '0;
    if (!n_rst) begin
      model_reset();
    end else if (j > m_end && fifo.size() > 0 && !bus.halt_i) begin
      m_have = 1'b1;
      m_fc   = j + 1;
      m_word = fifo[0];
      m_op   = m_word[3:0];
      if (eng(m_op) != 3'b000) begin
        m_dly = next_delay(20);
        m_tmo = (m_dly >= TO);
        m_end = m_fc + 3 + (m_tmo ? TO - 1 : m_dly);
      end else if (m_op == 4'd4) begin
        m_dly = next_delay(8);
        m_tmo = 1'b0;
        m_end = m_fc + 2 + m_dly;
      end else begin
        m_tmo = 1'b0;
        m_end = m_fc + 1;
      end
    end
    if (bus.pop_o) begin
      chk("pop_nonempty", fifo.size() > 0, 1);
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    predict(j + 1, bus.clear_err_i);
  endtask

  task automatic clear_logs();
    pop_log.delete(); st_cyc.delete(); st_val.delete(); ab_log.delete();
    swap_hi = 0;
  endtask

  task automatic run_to_wait(input string nm);
    int k;
    k = 0;
    while (!(m_have && cyc >= m_fc + 3 && cyc <= m_end) && k < 50) begin
      step();
      k++;
    end
    chk(nm, k < 50, 1);
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("pop_o", bus.pop_o, exp_pop);
    chk("busy_o", bus.busy_o, exp_busy);
    chk("start_o", bus.start_o, exp_start);
    chk("abort_o", bus.abort_o, exp_abort);
    chk("swap_req_o", bus.swap_req_o, exp_swap);
    chk("illegal_op_o", bus.illegal_op_o, exp_ill);
    chk("timeout_err_o", bus.timeout_err_o, exp_tmo);
    chk("instr_count_o", bus.instr_count_o, exp_count);
    chk("instr_o", bus.instr_o, exp_instr);
    if (bus.pop_o) pop_log.push_back(cyc);
    if (bus.start_o != 3'b000) begin st_cyc.push_back(cyc); st_val.push_back(bus.start_o); end
    if (bus.abort_o) ab_log.push_back(cyc);
    if (bus.swap_req_o) swap_hi++;
  end

  initial begin
    logic [W-1:0] w_line;
    int           rel_cyc;
    bus.fifo_empty_i = 1'b1; bus.instr_i = '0; bus.done_i = 3'b000;
    bus.swap_ack_i = 1'b0; bus.halt_i = 1'b0; bus.clear_err_i = 1'b0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;

    // reset with a LINE already waiting in the FIFO
    w_line = mkw(4'd1);
    fifo.push_back(w_line);
    dly_q.push_back(3);
    repeat (2) step();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_pop", bus.pop_o, 0);
    chk("rst_start", bus.start_o, 0);
    chk("rst_count", bus.instr_count_o, 0);
    chk("rst_instr", bus.instr_o, 0);
    clear_logs();
    rst_drive = 1'b1;
    step();
    rel_cyc = cyc;
    repeat (12) step();
    chk("t1_pop_lat", pop_log.size() > 0 ? pop_log[0] - rel_cyc : -1, 1);
    chk("t1_start_lat", (pop_log.size() > 0 && st_cyc.size() > 0) ? st_cyc[0] - pop_log[0] : -1, 2);
    chk("t1_start_val", st_val.size() > 0 ? st_val[0] : 3'b111, 3'b001);
    chk("t1_instr", bus.instr_o, w_line);
    chk("t1_count", bus.instr_count_o, 1);

    // RECT then CIRCLE, done 10 cycles into each wait, foreign done bits as noise
    clear_logs();
    fifo.push_back(mkw(4'd2)); fifo.push_back(mkw(4'd3));
    dly_q.push_back(10); dly_q.push_back(10);
    repeat (40) step();
    chk("t2_pops", pop_log.size(), 2);
    chk("t2_start0", st_val.size() > 0 ? st_val[0] : 3'b111, 3'b010);
    chk("t2_start1", st_val.size() > 1 ? st_val[1] : 3'b111, 3'b100);
    chk("t2_gap", st_cyc.size() > 1 ? st_cyc[1] - st_cyc[0] : -1, 15);
    chk("t2_count", bus.instr_count_o, 3);

    // SWAP acked on its 8th cycle, then an illegal opcode
    clear_logs();
    fifo.push_back(mkw(4'd4)); fifo.push_back(mkw(4'd9));
    dly_q.push_back(7);
    repeat (30) step();
    chk("t3_swap_len", swap_hi, 8);
    chk("t3_no_start", st_cyc.size(), 0);
    chk("t3_illegal", bus.illegal_op_o, 1);
    chk("t3_count", bus.instr_count_o, 4);

    // LINE that never finishes
    clear_logs();
    fifo.push_back(mkw(4'd1));
    dly_q.push_back(99);
    repeat (30) step();
    chk("t4_aborts", ab_log.size(), 1);
    chk("t4_abort_lat", (ab_log.size() > 0 && st_cyc.size() > 0) ? ab_log[0] - st_cyc[0] : -1, 17);
    chk("t4_tmo", bus.timeout_err_o, 1);
    chk("t4_count", bus.instr_count_o, 4);
    clr_once = 1'b1;
    repeat (2) step();
    chk("t4_tmo_clr", bus.timeout_err_o, 0);
    chk("t4_ill_clr", bus.illegal_op_o, 0);

    // halt raised while waiting with three more queued
    fifo.push_back(mkw(4'd1));
    dly_q.push_back(12);
    run_to_wait("t5_reach_wait");
    fifo.push_back(mkw(4'd1)); fifo.push_back(mkw(4'd2)); fifo.push_back(mkw(4'd3));
    dly_q.push_back(2); dly_q.push_back(4); dly_q.push_back(6);
    clear_logs();
    halt_mode = 1;
    repeat (40) step();
    chk("t5_halt_pops", pop_log.size(), 0);
    chk("t5_halt_fifo", fifo.size(), 3);
    chk("t5_halt_busy", bus.busy_o, 0);
    chk("t5_halt_count", bus.instr_count_o, 5);
    halt_mode = 0;
    repeat (60) step();
    chk("t5_drain_pops", pop_log.size(), 3);
    chk("t5_drain_count", bus.instr_count_o, 8);

    // asynchronous reset in the middle of a wait
    fifo.push_back(mkw(4'd2));
    dly_q.push_back(99);
    run_to_wait("t5_reach_wait2");
    rst_drive = 1'b0;
    n_rst     = 1'b0;
    #1;
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_start", bus.start_o, 0);
    chk("arst_pop", bus.pop_o, 0);
    chk("arst_abort", bus.abort_o, 0);
    chk("arst_swap", bus.swap_req_o, 0);
    chk("arst_count", bus.instr_count_o, 0);
    chk("arst_instr", bus.instr_o, 0);
    model_reset();
    repeat (3) step();
    rst_drive = 1'b1;

    // randomized traffic
    push_rate = 35;
    halt_mode = 2;
    clr_rand  = 1'b1;
    repeat (3000) step();
    push_rate = 0;
    halt_mode = 0;
    clr_rand  = 1'b0;
    repeat (120) step();
    chk("final_drained", fifo.size(), 0);
    chk("final_idle", bus.busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
